// File: rtl/step_sequencer.sv
// Step sequencer: walks an index through NUM_STEPS positions, dwelling
// TICKS_PER_STEP one-shot timer expiries on each, re-arming the timer per tick.
module step_sequencer #(
   parameter int NUM_STEPS      = 8,
   parameter int STEP_W         = 3,
   parameter int TICKS_PER_STEP = 4,
   parameter int TICK_W         = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_go,
   input  logic              i_abort,
   input  logic              i_loop,
   input  logic              i_tmr_pulse,
   output logic              o_start_tmr,
   output logic [STEP_W-1:0] o_step,
   output logic              o_step_valid,
   output logic              o_step_adv,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_WAIT   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [TICK_W-1:0] LP_TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
   localparam logic [STEP_W-1:0] LP_STEP_LAST = STEP_W'(NUM_STEPS - 1);

   state_t              r_state;
   logic [TICK_W-1:0]   r_tick;
   logic [STEP_W-1:0]   r_step;
   logic                r_start_tmr;
   logic                r_step_valid;
   logic                r_step_adv;
   logic                r_busy;
   logic                r_done;

   logic                w_tick_last;
   logic                w_step_last;

   assign w_tick_last = (r_tick == LP_TICK_LAST);
   assign w_step_last = (r_step == LP_STEP_LAST);

   // Every output is a register; strobes default low and are set only on the
   // edge that enters the state they belong to.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_tick       <= '0;
         r_step       <= '0;
         r_start_tmr  <= 1'b0;
         r_step_valid <= 1'b0;
         r_step_adv   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_start_tmr <= 1'b0;
         r_step_adv  <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_go) begin
                  r_state      <= S_ARM;
                  r_step       <= '0;
                  r_tick       <= '0;
                  r_step_adv   <= 1'b1;
                  r_start_tmr  <= 1'b1;
                  r_step_valid <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            S_ARM: begin
               if (i_abort) begin
                  r_state      <= S_IDLE;
                  r_tick       <= '0;
                  r_step_valid <= 1'b0;
                  r_busy       <= 1'b0;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_abort) begin
                  r_state      <= S_IDLE;
                  r_tick       <= '0;
                  r_step_valid <= 1'b0;
                  r_busy       <= 1'b0;
               end else if (i_tmr_pulse) begin
                  if (!w_tick_last) begin
                     r_tick      <= r_tick + TICK_W'(1);
                     r_state     <= S_ARM;
                     r_start_tmr <= 1'b1;
                  end else begin
                     r_tick <= '0;
                     if (!w_step_last) begin
                        r_step      <= r_step + STEP_W'(1);
                        r_step_adv  <= 1'b1;
                        r_state     <= S_ARM;
                        r_start_tmr <= 1'b1;
                     end else if (i_loop) begin
                        // Explicit wrap keeps non-power-of-two step counts correct
                        r_step      <= '0;
                        r_step_adv  <= 1'b1;
                        r_state     <= S_ARM;
                        r_start_tmr <= 1'b1;
                     end else begin
                        r_state      <= S_FINISH;
                        r_done       <= 1'b1;
                        r_step_valid <= 1'b0;
                     end
                  end
               end
            end
            S_FINISH: begin
               r_state      <= S_IDLE;
               r_tick       <= '0;
               r_step_valid <= 1'b0;
               r_busy       <= 1'b0;
            end
            default: begin
               r_state      <= S_IDLE;
               r_tick       <= '0;
               r_step_valid <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign o_start_tmr  = r_start_tmr;
   assign o_step       = r_step;
   assign o_step_valid = r_step_valid;
   assign o_step_adv   = r_step_adv;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: scenario tasks plus random traffic, checked against
// a pulse-counting reference model and a 5-cycle one-shot timer model.
`timescale 1ns/1ps
module tb_step_sequencer;
   localparam int N   = 4;
   localparam int TPS = 2;
   localparam int SW  = 2;
   localparam int TW  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          i_rst_n = 1'b0;
   logic          i_go = 1'b0;
   logic          i_abort = 1'b0;
   logic          i_loop = 1'b0;
   logic          tmr_auto = 1'b0;
   logic          man_pulse = 1'b0;
   logic          tmr_en = 1'b1;
   logic          i_tmr_pulse;
   logic          o_start_tmr;
   logic [SW-1:0] o_step;
   logic          o_step_valid;
   logic          o_step_adv;
   logic          o_busy;
   logic          o_done;

   assign i_tmr_pulse = tmr_auto | man_pulse;

   int errors = 0;
   int checks = 0;

   step_sequencer #(
      .NUM_STEPS(N), .STEP_W(SW), .TICKS_PER_STEP(TPS), .TICK_W(TW)
   ) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_go(i_go), .i_abort(i_abort),
      .i_loop(i_loop), .i_tmr_pulse(i_tmr_pulse), .o_start_tmr(o_start_tmr),
      .o_step(o_step), .o_step_valid(o_step_valid), .o_step_adv(o_step_adv),
      .o_busy(o_busy), .o_done(o_done)
   );

   wire [6:0] act_vec = {o_busy, o_step_valid, o_start_tmr, o_step_adv, o_done, o_step};

   // One-shot timer: expires 5 cycles after it sees a start strobe.
   int tcnt = 0;
   always @(negedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tcnt     = 0;
         tmr_auto = 1'b0;
      end else begin
         tmr_auto = 1'b0;
         if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) tmr_auto = 1'b1;
         end
         if (o_start_tmr && tmr_en) tcnt = 5;
      end
   end

   // Reference model: the position is derived from pulses accepted this pass.
   bit m_run, m_arm, m_fin, m_adv, m_pulse_edge;
   int m_acc, m_step;
   always @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_run = 0; m_arm = 0; m_fin = 0; m_adv = 0; m_pulse_edge = 0;
         m_acc = 0; m_step = 0;
      end else begin
         m_adv = 0;
         m_pulse_edge = i_tmr_pulse;
         if (!(m_run || m_fin)) begin
            if (i_go) begin
               m_run = 1; m_arm = 1; m_acc = 0; m_step = 0; m_adv = 1;
            end
         end else if (i_abort) begin
            m_run = 0; m_arm = 0; m_fin = 0;
         end else if (m_fin) begin
            m_fin = 0;
         end else if (m_arm) begin
            m_arm = 0;
         end else if (i_tmr_pulse) begin
            m_acc++;
            if (m_acc % TPS != 0) begin
               m_arm = 1;
            end else if (((m_acc / TPS) % N) != 0 || i_loop) begin
               m_step = (m_acc / TPS) % N;
               m_adv  = 1;
               m_arm  = 1;
            end else begin
               m_run = 0;
               m_fin = 1;
            end
         end
      end
   end

   function automatic logic [6:0] exp_vec();
      return {m_run | m_fin, m_run, m_arm, m_adv, m_fin, 2'(m_step)};
   endfunction

   task automatic test_reset();
      i_rst_n = 1'b0; i_go = 0; i_abort = 0; i_loop = 0; man_pulse = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (act_vec !== 7'b0) begin
         errors++; $display("FAIL reset_outputs act=%b exp=%b", act_vec, 7'b0);
      end
      i_rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (act_vec !== 7'b0) begin
         errors++; $display("FAIL idle_after_reset act=%b exp=%b", act_vec, 7'b0);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_pass();
      int starts = 0, advs = 0, dones = 0;
      bit done_seen = 0;
      i_loop = 0; i_go = 1;
      for (int c = 0; c < 200 && !done_seen; c++) begin
         @(negedge clk);
         i_go = 0;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL pass_vec t=%0t act=%b exp=%b", $time, act_vec, exp_vec());
         end
         if (o_start_tmr) starts++;
         if (o_step_adv) advs++;
         if (o_done) begin
            dones++; done_seen = 1;
            checks++;
            if (!m_pulse_edge) begin
               errors++; $display("FAIL done_latency pulse_prev_edge=%0b exp=1", m_pulse_edge);
            end
         end
      end
      checks++;
      if (starts != 8) begin errors++; $display("FAIL pass_starts act=%0d exp=8", starts); end
      checks++;
      if (advs != 4) begin errors++; $display("FAIL pass_advs act=%0d exp=4", advs); end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL pass_dones act=%0d exp=1", dones); end
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_step !== 2'd3) begin
         errors++; $display("FAIL pass_end busy=%b step=%0d exp busy=0 step=3", o_busy, o_step);
      end
      $display("test_single_pass starts=%0d advs=%0d dones=%0d", starts, advs, dones);
   endtask

   task automatic test_loop();
      int wraps = 0;
      bit cleared = 0, done_seen = 0;
      logic [SW-1:0] prev_step = '0;
      i_loop = 1; i_go = 1;
      for (int c = 0; c < 400 && !done_seen; c++) begin
         @(negedge clk);
         i_go = 0;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL loop_vec t=%0t act=%b exp=%b", $time, act_vec, exp_vec());
         end
         if (o_step_adv && o_step == 2'd0 && prev_step == 2'd3) wraps++;
         if (o_done) begin
            done_seen = 1;
            checks++;
            if (!cleared) begin
               errors++; $display("FAIL done_while_loop cleared=%0b exp=1", cleared);
            end
         end
         if (!cleared && wraps >= 1 && o_step == 2'd3) begin
            i_loop = 0; cleared = 1;
         end
         prev_step = o_step;
      end
      checks++;
      if (wraps != 1) begin errors++; $display("FAIL loop_wraps act=%0d exp=1", wraps); end
      checks++;
      if (!done_seen) begin errors++; $display("FAIL loop_exit_done act=0 exp=1"); end
      @(negedge clk);
      $display("test_loop wraps=%0d done=%0b", wraps, done_seen);
   endtask

   task automatic test_abort();
      int cd = 0;
      bit aborted = 0;
      tmr_en = 0; i_loop = 0; i_go = 1;
      for (int c = 0; c < 200 && !aborted; c++) begin
         @(negedge clk);
         i_go = 0; man_pulse = 0;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL abort_vec t=%0t act=%b exp=%b", $time, act_vec, exp_vec());
         end
         if (o_start_tmr) cd = 5;
         else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               man_pulse = 1;
               if (o_step == 2'd2) begin i_abort = 1; aborted = 1; end
            end
         end
      end
      checks++;
      if (!aborted) begin errors++; $display("FAIL abort_reach_step2 act=0 exp=1"); end
      @(negedge clk);
      i_abort = 0; man_pulse = 0;
      checks++;
      if ({o_busy, o_step_valid, o_step_adv, o_done, o_start_tmr} !== 5'b0 || o_step !== 2'd2) begin
         errors++; $display("FAIL abort_idle act=%b exp busy/valid/adv/done/start=0 step=2", act_vec);
      end
      for (int k = 0; k < 6; k++) begin
         man_pulse = (k == 1 || k == 3);
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec() || o_busy !== 1'b0 || o_step !== 2'd2) begin
            errors++; $display("FAIL stray_pulse act=%b exp=%b", act_vec, exp_vec());
         end
      end
      man_pulse = 0; tmr_en = 1;
      $display("test_abort step=%0d busy=%0b", o_step, o_busy);
   endtask

   task automatic test_go_busy();
      int starts = 0;
      bit done_seen = 0;
      i_loop = 0; i_go = 1;
      for (int c = 0; c < 200 && !done_seen; c++) begin
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL gobusy_vec t=%0t act=%b exp=%b", $time, act_vec, exp_vec());
         end
         if (o_start_tmr) starts++;
         if (o_done) done_seen = 1;
      end
      checks++;
      if (starts != 8 || !done_seen) begin
         errors++; $display("FAIL go_busy_starts act=%0d done=%0b exp=8 done=1", starts, done_seen);
      end
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || act_vec !== exp_vec()) begin
         errors++; $display("FAIL idle_after_done act=%b exp=%b", act_vec, exp_vec());
      end
      @(negedge clk);
      i_go = 0;
      checks++;
      if (!(o_busy === 1'b1 && o_step_adv === 1'b1 && o_start_tmr === 1'b1 && o_step === 2'd0)) begin
         errors++; $display("FAIL restart_after_done act=%b exp busy=1 adv=1 start=1 step=0", act_vec);
      end
      i_abort = 1;
      @(negedge clk);
      i_abort = 0;
      checks++;
      if (act_vec !== exp_vec() || o_busy !== 1'b0) begin
         errors++; $display("FAIL gobusy_abort act=%b exp=%b", act_vec, exp_vec());
      end
      $display("test_go_busy starts=%0d", starts);
   endtask

   task automatic test_async_reset();
      bit found = 0, done_seen = 0;
      i_loop = 0; i_go = 1;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         i_go = 0;
         if (o_step == 2'd1 && o_step_valid && !o_start_tmr) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL async_reach_wait act=0 exp=1"); end
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if (act_vec !== 7'b0) begin
         errors++; $display("FAIL async_reset act=%b exp=%b", act_vec, 7'b0);
      end
      repeat (2) @(negedge clk);
      i_rst_n = 1'b1; i_go = 1;
      for (int c = 0; c < 200 && !done_seen; c++) begin
         @(negedge clk);
         i_go = 0;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL post_reset_vec t=%0t act=%b exp=%b", $time, act_vec, exp_vec());
         end
         if (o_done) done_seen = 1;
      end
      checks++;
      if (!done_seen) begin errors++; $display("FAIL post_reset_done act=0 exp=1"); end
      @(negedge clk);
      $display("test_async_reset done=%0b", done_seen);
   endtask

   task automatic test_random();
      bit pending = 0;
      logic [SW-1:0] prev_step = o_step;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL rand_vec t=%0t act=%b exp=%b", $time, act_vec, exp_vec());
         end
         if (m_pulse_edge || !o_busy) pending = 0;
         if (o_start_tmr) begin
            checks++;
            if (pending) begin
               errors++; $display("FAIL start_twice t=%0t act=1 exp=0", $time);
            end
            pending = 1;
         end
         checks++;
         if (o_step !== prev_step && !o_step_adv) begin
            errors++; $display("FAIL step_without_adv t=%0t step=%0d prev=%0d adv=0 exp=1", $time, o_step, prev_step);
         end
         prev_step = o_step;
         i_go      = ($urandom % 6 == 0);
         i_abort   = ($urandom % 50 == 0);
         if ($urandom % 20 == 0) i_loop = ~i_loop;
         man_pulse = ($urandom % 25 == 0);
      end
      i_go = 0; i_abort = 0; man_pulse = 0;
      $display("test_random cycles=3000");
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_loop();
      test_abort();
      test_go_busy();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
